maxpool_flatten_streamer: RTL and testbench
===========================================

# maxpool_flatten_streamer

Downstream stage of the first 2×2 max-pooling layer. On a start pulse it captures the pooled feature map (2 channels × 14 × 14, signed, parallel) into an internal frame buffer. It then streams the 392 elements one per handshake over a valid/ready interface, in flatten order, to the fully-connected layer. It decouples the wide combinational pooling output from the serial dense-layer datapath and absorbs downstream backpressure.

## Interface
Parameters:
- bitwidth, 8, signed element width (same as the pooling stage)
- CHANNELS, 2, feature-map channels
- DIM, 14, pooled map height = width
- IDX_W, 9, index width; must satisfy 2^IDX_W ≥ CHANNELS·DIM·DIM (392)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  capture request; sampled only in IDLE
- featuremap_maxpooled  input  signed [bitwidth-1:0] [CHANNELS-1:0][DIM-1:0][DIM-1:0]  pooled map from the pooling stage
- out_ready  input  1  downstream can accept
- out_valid  output  1  out_data/out_index/out_last are valid
- out_data  output  signed bitwidth  current element
- out_index  output  IDX_W  flat index of current element
- out_last  output  1  high with element CHANNELS·DIM·DIM−1
- busy  output  1  frame captured and not fully streamed
- done  output  1  one-cycle pulse after final handshake

## Operation
- Flatten order: index = c·DIM·DIM + i·DIM + j, with j fastest and c slowest. Element k = featuremap_maxpooled[c][i][j].
- FSM states:
  - IDLE: waiting for start.
  - STREAM: emitting elements.
  - DONE: one cycle, pulsing done.
- FSM transitions:
  - IDLE → STREAM on start: capture the full input array into the frame buffer, set counter k = 0.
  - In STREAM, a handshake is out_valid && out_ready. On a handshake with k < 391, k ← k+1. On a handshake with k = 391, go to DONE.
  - DONE → IDLE unconditionally.
- The frame buffer is written only on the IDLE→STREAM transition. Input changes during STREAM/DONE have no effect on streamed data.
- start is ignored in STREAM and DONE; it is not queued. start in the DONE cycle is also ignored.
- out_valid = (state == STREAM). out_data/out_index/out_last are driven from the registered buffer and counter.
- While out_valid && !out_ready: out_data, out_index and out_last hold stable. out_valid never drops before its handshake.
- busy = (state == STREAM || state == DONE).
- out_ready is ignored outside STREAM.
- Reset values: state IDLE; k 0; out_valid 0; out_last 0; out_data 0; out_index 0; busy 0; done 0. The frame buffer need not be reset.
- Reset mid-stream: the next cycle is IDLE with all outputs at reset values. The partial frame is abandoned and no done is pulsed.

## Timing
- start high at edge t (in IDLE) → out_valid high from t+1 with index 0.
- With out_ready held high, one element per cycle. The last handshake is at t+392 and done is high during cycle t+393.
- Minimum frame period is 394 cycles: start accepted again in IDLE at t+394.
- Each stall cycle (out_ready low) adds exactly one cycle. There is no combinational path from out_ready to out_valid.

## Configuration
- FLATTEN_RELU_EN defined: out_data = (element < 0) ? 0 : element, applied at output. out_index/out_last are unaffected.
- FLATTEN_RELU_EN undefined: out_data is the captured signed element unchanged.

## Test plan
- Reset: assert rst for 2 cycles mid-stream (k = 100) → next cycle out_valid=0, busy=0, done=0, out_index=0. A new start then streams from index 0.
- Full frame, out_ready=1, input fm[c][i][j] = c·64 + i·4 + (j&3) (fits signed 8-bit):
  - index 0 → fm[0][0][0].
  - index 195 → fm[0][13][13].
  - index 196 → fm[1][0][0].
  - index 391 → fm[1][13][13] with out_last=1.
  - done exactly one cycle later.
- Backpressure: drop out_ready at index 10 for 5 cycles → index 10 data held stable, out_valid stays 1, total frame length 397 cycles.
- Capture isolation and start-while-busy: change the input map and pulse start at index 50 → stream continues with the original data, and no restart occurs.
- Config: element value −5 (8'hFB) → out_data 0 with FLATTEN_RELU_EN, 8'hFB without. Value +7 → 7 in both builds.

Source files
------------

// File: rtl/maxpool_flatten_streamer.sv
// Captures a pooled feature map and streams it in flatten order over valid/ready.
// Build option: define FLATTEN_RELU_EN to clamp negative output elements to zero.
module maxpool_flatten_streamer #(
  parameter int bitwidth = 8,
  parameter int CHANNELS = 2,
  parameter int DIM      = 14,
  parameter int IDX_W    = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [bitwidth-1:0] featuremap_maxpooled
                                       [CHANNELS-1:0][DIM-1:0][DIM-1:0],
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [bitwidth-1:0] out_data,
  output logic [IDX_W-1:0]           out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int N  = CHANNELS * DIM * DIM;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [IDX_W-1:0] KLAST = IDX_W'(N - 1);
  localparam logic [CW-1:0]    CLAST = CW'(CHANNELS - 1);
  localparam logic [DW-1:0]    DLAST = DW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] k_q;
  logic [CW-1:0]    c_q;
  logic [DW-1:0]    i_q;
  logic [DW-1:0]    j_q;
  logic             cap;
  logic             hs;
  logic             k_last;

  logic signed [bitwidth-1:0] frame_q [CHANNELS-1:0][DIM-1:0][DIM-1:0];
  logic signed [bitwidth-1:0] elem;

  assign k_last = (k_q == KLAST);

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          hs = 1'b1;
          if (k_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cap || (hs && k_last)) begin
        k_q <= '0;
        c_q <= '0;
        i_q <= '0;
        j_q <= '0;
      end else if (hs) begin
        k_q <= k_q + IDX_W'(1);
        if (j_q == DLAST) begin
          j_q <= '0;
          if (i_q == DLAST) begin
            i_q <= '0;
            c_q <= (c_q == CLAST) ? '0 : c_q + CW'(1);
          end else begin
            i_q <= i_q + DW'(1);
          end
        end else begin
          j_q <= j_q + DW'(1);
        end
      end
    end
  end

  // Frame buffer only loads on capture, so input changes mid-stream are invisible.
  always_ff @(posedge clk) begin
    if (cap) frame_q <= featuremap_maxpooled;
  end

  assign elem = frame_q[c_q][i_q][j_q];

  assign out_valid = (state_q == STREAM);
  assign out_index = k_q;
  assign out_last  = out_valid && k_last;
  assign busy      = (state_q == STREAM) || (state_q == DONE);
  assign done      = (state_q == DONE);

`ifdef FLATTEN_RELU_EN
  assign out_data = (out_valid && !elem[bitwidth-1]) ? elem : '0;
`else
  assign out_data = out_valid ? elem : '0;
`endif

endmodule

// File: tb/tb_maxpool_flatten_streamer.sv
// Scoreboard bench for maxpool_flatten_streamer.
// Expected data applies the same clamp when FLATTEN_RELU_EN is defined.
module tb_maxpool_flatten_streamer;

  localparam int N = 392;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic out_ready;
  logic signed [7:0] fm [1:0][13:0][13:0];
  logic out_valid;
  logic signed [7:0] out_data;
  logic [8:0] out_index;
  logic out_last;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  logic [7:0] qd[$];
  logic [8:0] qi[$];

  always #5 clk = ~clk;

  maxpool_flatten_streamer #(
    .bitwidth(8), .CHANNELS(2), .DIM(14), .IDX_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .featuremap_maxpooled(fm),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 14; i++)
        for (int j = 0; j < 14; j++)
          if (pat == 0) fm[c][i][j] = 8'(c * 64 + i * 4 + (j & 3));
          else if (pat == 1) fm[c][i][j] = 8'($urandom_range(0, 255));
          else fm[c][i][j] = ~fm[c][i][j];
    if (pat == 1) begin
      fm[0][0][0] = 8'shFB;
      fm[0][0][1] = 8'sh07;
    end
  endtask

  task automatic push_frame();
    logic signed [7:0] v;
    qd.delete();
    qi.delete();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 14; i++)
        for (int j = 0; j < 14; j++) begin
          v = fm[c][i][j];
`ifdef FLATTEN_RELU_EN
          if (v < 0) v = 8'sd0;
`endif
          qd.push_back(v);
          qi.push_back(9'(c * 196 + i * 14 + j));
        end
  endtask

  task automatic frame(input int stall_at, input int stall_len,
                       input int dist_at, input int rst_at);
    int vcyc;
    int guard;
    int stalls;
    bit fin;
    push_frame();
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("valid_after_start", 32'(out_valid), 32'd1);
    chk("first_index", 32'(out_index), 32'd0);
    vcyc = 0;
    guard = 0;
    stalls = stall_len;
    fin = 1'b0;
    while (!fin && guard < 1000) begin
      guard++;
      if (!out_valid) begin
        chk("valid_dropped", 32'(out_valid), 32'd1);
        fin = 1'b1;
      end else begin
        vcyc++;
        chk("done_mid", 32'(done), 32'd0);
        if (rst_at >= 0 && int'(out_index) == rst_at) begin
          rst = 1'b1;
          tick();
          chk("rst_valid", 32'(out_valid), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_index", 32'(out_index), 32'd0);
          chk("rst_last", 32'(out_last), 32'd0);
          chk("rst_data", {24'b0, out_data}, 32'd0);
          tick();
          rst = 1'b0;
          chk("rst_hold_valid", 32'(out_valid), 32'd0);
          qd.delete();
          qi.delete();
          return;
        end
        if (dist_at >= 0 && int'(out_index) == dist_at) begin
          fill(2);
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        out_ready = !(int'(out_index) == stall_at && stalls > 0);
        if (!out_ready) stalls--;
        chk("data", {24'b0, out_data}, {24'b0, qd[0]});
        chk("index", 32'(out_index), 32'(qi[0]));
        chk("last", 32'(out_last), 32'(qi[0] == 9'd391));
        if (out_ready) begin
          if (qi[0] == 9'd391) fin = 1'b1;
          void'(qd.pop_front());
          void'(qi.pop_front());
        end
        tick();
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("frame_len", 32'(vcyc), 32'(N + stall_len));
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("no_restart", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    fill(0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_index", 32'(out_index), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    chk("reset_data", {24'b0, out_data}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("idle_ready_ignored", 32'(out_valid), 32'd0);

    frame(-1, 0, -1, -1);
    frame(10, 5, -1, -1);
    fill(0);
    frame(-1, 0, 50, -1);
    fill(0);
    frame(-1, 0, -1, 100);
    fill(1);
    frame(-1, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
